led_sched: RTL
==============

# led_sched

RGB LED pattern scheduler for the QuickFeather FPGA fabric. It replaces the fixed free-running blink counter with a sequenced pattern:

- A small step table holds colour/duration pairs and is written over a simple config port (CPU-side glue or a test harness).
- Steps are played at a prescaled tick rate, with start/stop control and optional looping.
- It drives the board's red, green and blue LED pins directly from the Sys_Clk0 domain.

## Interface

Parameters:
- TICK_DIV, 120000: clk cycles per duration tick (10 ms at 12 MHz); must be ≥2.
- DEPTH, 8: number of step-table entries; power of two, 2..16.

Ports:
- clk  in  1  fabric clock (Sys_Clk0 domain)
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  step-table write strobe
- cfg_addr  in  $clog2(DEPTH)  step index to write
- cfg_data  in  11  {rgb[2:0], dur[7:0]}; dur=0 marks the terminator
- start  in  1  single-cycle request to begin playback from step 0
- stop  in  1  single-cycle request to abort playback
- loop_en  in  1  level; sampled at end-of-table
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on natural completion
- step_idx  out  $clog2(DEPTH)  index of the step currently displayed
- redled, greenled, blueled  out  1 each  LED drive, active-high

## Operation

- State machine has two states, IDLE and RUN.
- Reset values:
  - state is IDLE.
  - busy, done, step_idx and all LEDs are 0.
  - Table contents are 0, so every entry is a terminator.
  - Prescaler and duration counter are 0.
- **Table writes.** cfg_we writes the entry every cycle, in any state. A write to the step currently displayed does not alter it, because the active rgb/dur is latched at step load. A write to any other entry takes effect when that entry is loaded.
- **IDLE → RUN.** On start with stop low:
  - If entry 0 has dur≠0: load step 0, busy=1, LEDs=rgb0.
  - If entry 0 has dur=0: stay IDLE, pulse done, LEDs stay 0.
- **Step advance in RUN.** When the step's final tick expires:
  - Next index is i+1; if i=DEPTH-1, the next index wraps to 0 when loop_en=1, otherwise playback ends.
  - A next entry with dur=0 always ends playback, whatever loop_en is. This prevents a zero-length infinite loop.
- **End of playback.** → IDLE, LEDs=0, busy=0, step_idx=0, done=1 for one cycle.
- **stop.**
  - In RUN: → IDLE next cycle, LEDs=0, busy=0, step_idx=0, no done pulse.
  - stop has priority over start in the same cycle.
  - In IDLE: ignored.
- **start while in RUN:** ignored; no restart.
- **rst mid-playback:** all outputs return to reset values the next cycle. Table contents are also cleared.
- **Arithmetic.**
  - Prescaler counts 0..TICK_DIV-1 and cleans to 0 on every step load.
  - Duration counter is 8-bit and counts ticks 1..dur.
  - A step therefore lasts exactly dur×TICK_DIV cycles; no off-by-one.

## Timing

- start sampled at edge T → RUN with LEDs=rgb0 and busy=1 visible after edge T+1 (1-cycle latency).
- Step k is displayed for exactly dur_k×TICK_DIV consecutive cycles. The next step's rgb appears on the first cycle after that, with no gap cycle and no LED glitch between steps.
- done asserts in the first IDLE cycle, the same cycle LEDs go to 0. It is never asserted for 2 consecutive cycles.
- stop sampled at edge S → LEDs 0 and busy 0 after edge S+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package led_sched_pkg holds:
  - state enum {IDLE, RUN};
  - STEP_W=11, DUR_W=8 and RGB_W=3;
  - step field slice constants;
  - a step struct {rgb, dur}.
- Sub-module led_tick_prescaler:
  - parameter TICK_DIV;
  - inputs clk, rst, clr;
  - outputs a one-cycle tick pulse on count TICK_DIV-1.
- Step table is a DEPTH×11 register array, which is small enough for flops rather than RAM.

## Test plan

Simulate with TICK_DIV=4 and DEPTH=8.

- Load {R,dur2},{G,dur1},{0,0}, then pulse start → red for 8 cycles, green for 4, then LEDs 0 and done pulse 1 cycle; busy high for exactly 12 cycles.
- Fill all 8 entries with dur=1 and alternating B/G, set loop_en=1 and start → step_idx wraps 7→0 with no done. Deassert loop_en mid-run → done at the next end of step 7.
- Issue stop 5 cycles into a dur=3 step → LEDs 0 and busy 0 one cycle later, no done. Assert start and stop in the same cycle → stays IDLE.
- Entry 0 has dur=0 and start is pulsed → done pulse, busy never rises, LEDs stay 0.
- While step 1 plays, rewrite step 1 to blue and step 2 to red, dur1 → current colour unchanged; step 2 shows red.
- Assert rst during RUN, step 3 → next cycle all outputs 0 and table cleared. A subsequent start yields an immediate done.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the RGB LED pattern scheduler.
package led_sched_pkg;

    localparam int STEP_W = 11;
    localparam int DUR_W  = 8;
    localparam int RGB_W  = 3;

    // Field positions inside a packed step word {rgb, dur}
    localparam int DUR_LSB = 0;
    localparam int DUR_MSB = DUR_W - 1;
    localparam int RGB_LSB = DUR_W;
    localparam int RGB_MSB = STEP_W - 1;

    // Playback state; RUN is what busy reports
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;   // {red, green, blue}
        logic [DUR_W-1:0] dur;   // ticks; 0 marks the terminator
    } step_t;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV clocks,
// restarted from zero whenever clr is high.
module led_tick_prescaler #(
    parameter int TICK_DIV = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority, otherwise wrap at TICK_DIV-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_sched.sv
// RGB LED pattern scheduler: plays a table of {rgb, dur} steps at a
// prescaled tick rate with start/stop control and optional looping.
// All outputs come straight from registers.
module led_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_DIV = 120000,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [STEP_W-1:0]        cfg_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     redled,
    output logic                     greenled,
    output logic                     blueled
);

    localparam int AW = $clog2(DEPTH);

    step_t            tab_q [DEPTH];
    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load;
    logic             tick;
    logic [AW-1:0]    next_idx;
    step_t            next_step;
    logic             last_tick;
    logic             at_last_idx;

    // Prescaler restarts on every step load and stays parked while idle
    led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load || (state_d == IDLE)),
        .tick (tick)
    );

    assign next_idx    = idx_q + AW'(1);
    assign next_step   = tab_q[next_idx];
    assign at_last_idx = (idx_q == AW'(DEPTH - 1));
    assign last_tick   = tick && (8'(cnt_q + 8'd1) == dur_q);

    // Step table: written every cycle cfg_we is high, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tab_q[cfg_addr] <= step_t'(cfg_data);
        end
    end

    // Playback sequencing: start/stop, step advance, end-of-table handling
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rgb_d   = rgb_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (tab_q[0].dur != '0) begin
                        state_d = RUN;
                        idx_d   = '0;
                        rgb_d   = tab_q[0].rgb;
                        dur_d   = tab_q[0].dur;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end else begin
                        // Empty table: report completion, but never two
                        // done cycles back to back
                        done_d = !done_q;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    rgb_d   = '0;
                    cnt_d   = '0;
                end else if (last_tick) begin
                    // A zero-duration next entry always ends playback so a
                    // looping table can never spin on empty steps
                    if ((at_last_idx && !loop_en) || (next_step.dur == '0)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        rgb_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = next_idx;
                        rgb_d = next_step.rgb;
                        dur_d = next_step.dur;
                        cnt_d = '0;
                        load  = 1'b1;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                rgb_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rgb_q   <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rgb_q   <= rgb_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign step_idx = idx_q;
    assign redled   = rgb_q[2];
    assign greenled = rgb_q[1];
    assign blueled  = rgb_q[0];

endmodule
